// File: rtl/stream_array_port_pkg.sv
// Shared types and default sizes for the stream array port and its read queue.
package stream_array_port_pkg;

  localparam int DEF_N  = 2048;
  localparam int DEF_AW = 11;
  localparam int DEF_DW = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_array_rdq.sv
// Two-entry read-data FIFO; the head word stays stable until it is accepted.
// The caller only pushes when a free slot is guaranteed, so there is no in_ready.
module stream_array_rdq #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;

  assign push      = in_valid;
  assign pop       = out_ready && (cnt_q != 2'd0);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign count     = cnt_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      e0_d = e1_q;
      if (push) begin
        if (cnt_q == 2'd1) e0_d = in_data;
        else               e1_d = in_data;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) e0_d = in_data;
      else               e1_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule

// File: rtl/stream_array_port.sv
// Stream-side responder for an on-chip array: read, write and write-ack streams.
// Optional macro STREAM_ARRAY_INIT_EN adds a post-reset sweep writing INIT everywhere.
module stream_array_port
  import stream_array_port_pkg::*;
#(
  parameter int            N    = DEF_N,
  parameter int            AW   = DEF_AW,
  parameter int            DW   = DEF_DW,
  parameter logic [DW-1:0] INIT = DW'(64'h8000_0000)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [AW-1:0] ra,
  input  logic          ra_valid,
  output logic          ra_ready,
  output logic [DW-1:0] rd,
  output logic          rd_valid,
  input  logic          rd_ready,
  input  logic [AW-1:0] wa,
  input  logic          wa_valid,
  output logic          wa_ready,
  input  logic [DW-1:0] wd,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic          wb_valid,
  input  logic          wb_ready
);

  localparam int IW = $clog2(N);

  logic          run;
  logic          init_we;
  logic [IW-1:0] init_addr;
  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] rdata_q, rdata_d;
  logic          inflight_q, inflight_d;
  logic          ack_q, ack_d;
  logic          rd_fire, wr_fire, fwd;
  logic [1:0]    occ;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 33'(a) < 33'(N);
  endfunction

`ifdef STREAM_ARRAY_INIT_EN
  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + IW'(1);
        if (cnt_q == IW'(N - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign init_addr = cnt_q;
  assign run       = (state_q == ST_RUN);
`else
  state_e state;

  assign state     = ST_RUN;
  assign run       = (state == ST_RUN);
  assign init_we   = 1'b0;
  assign init_addr = '0;
`endif

  // Gating with nrst keeps every ready low while reset is held, even though RUN is the reset state.
  assign ra_ready = nrst && run && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2);
  assign wa_ready = nrst && run && (!ack_q || wb_ready);
  assign wd_ready = wa_ready;
  assign wb_valid = ack_q;

  assign rd_fire = ra_valid && ra_ready;
  assign wr_fire = wa_valid && wd_valid && wa_ready;
  assign fwd     = wr_fire && (wa == ra);

  always_comb begin
    ack_d = ack_q;
    if (wr_fire)       ack_d = 1'b1;
    else if (wb_ready) ack_d = 1'b0;
    inflight_d = rd_fire;
  end

  always_comb begin
    rdata_d = INIT;
    if (in_range(ra)) rdata_d = fwd ? wd : mem_q[ra[IW-1:0]];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init_we)                      mem_q[init_addr]   <= INIT;
    else if (wr_fire && in_range(wa)) mem_q[wa[IW-1:0]] <= wd;
    if (rd_fire) rdata_q <= rdata_d;
  end

  stream_array_rdq #(.DW(DW)) u_rdq (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (inflight_q),
    .in_data   (rdata_q),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd),
    .count     (occ)
  );

endmodule
